iter_multiplier: RTL and testbench

Parametrised iterative shift-add integer multiplier. It is the successor to the fixed 32-bit multiplier under the test_bench wrapper. It adds configurable width, a per-operation signed/unsigned mode, a full-width 2*WIDTH product, valid/ready handshakes on both sides, and optional early termination. It sits between the issue logic and the writeback path of the arithmetic unit.

---
 rtl/iter_multiplier_pkg.sv | 25 ++
 rtl/mult_abs.sv | 24 ++
 rtl/iter_multiplier.sv | 152 +++++++++++++++
 tb/tb_iter_multiplier.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_multiplier_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iter_multiplier_pkg
//  Description : Shared types and helpers for the iterative shift-add
//                multiplier. It provides the FSM state encoding and the
//                width of the iteration counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package iter_multiplier_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter must be able to hold the value WIDTH, because the exit test
  // compares the count against WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_abs.sv
`default_nettype none
// ============================================================================
//  Module      : mult_abs
//  Description : Combinational conditional two's-complement negate.
//                out_val = neg_en ? -in_val : in_val
//  Ports       : in_val  [W-1:0]  operand
//                neg_en           1 = negate
//                out_val [W-1:0]  result
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_val,
  input  logic         neg_en,
  output logic [W-1:0] out_val
);

  // The most negative input maps back to itself. Read as an unsigned value,
  // that is its correct magnitude.
  assign out_val = neg_en ? (~in_val + W'(1)) : in_val;

endmodule
`default_nettype wire

// File: rtl/iter_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : iter_multiplier
//  Description : Parametrised iterative shift-add multiplier with a
//                per-operation signed/unsigned mode and a full 2*WIDTH
//                product. It has valid/ready handshakes on the input and
//                output sides, and an optional early exit once the remaining
//                multiplier bits are all zero.
//  Ports       : clk, rst             clock, synchronous active-high reset
//                in_valid/in_ready    operand handshake (ready only in IDLE)
//                in_signed            1 = two's-complement operands
//                input_a, input_b     multiplicand, multiplier [WIDTH-1:0]
//                out_valid/out_ready  product handshake
//                output_z             product [2*WIDTH-1:0]
//                busy                 controller not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_multiplier
  import iter_multiplier_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     input_a,
  input  logic [WIDTH-1:0]     input_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   output_z,
  output logic                 busy
);

  localparam int             PW       = 2 * WIDTH;
  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);

  state_e          state_q, state_d;
  logic [PW-1:0]   mag_a_q, mag_a_d;      // multiplicand, shifts left
  logic [WIDTH-1:0] mag_b_q, mag_b_d;     // multiplier, shifts right
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            out_valid_q, out_valid_d;
  logic [PW-1:0]   output_z_q, output_z_d;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [PW-1:0]    result;

  // The operand magnitudes are taken only for signed operations.
  mult_abs #(.W(WIDTH)) u_abs_a (
    .in_val  (input_a),
    .neg_en  (in_signed & input_a[WIDTH-1]),
    .out_val (abs_a)
  );

  mult_abs #(.W(WIDTH)) u_abs_b (
    .in_val  (input_b),
    .neg_en  (in_signed & input_b[WIDTH-1]),
    .out_val (abs_b)
  );

  // Negating a zero accumulator yields zero, so neg needs no zero check.
  mult_abs #(.W(PW)) u_abs_z (
    .in_val  (acc_q),
    .neg_en  (neg_q),
    .out_val (result)
  );

  always_comb begin
    state_d     = state_q;
    mag_a_d     = mag_a_q;
    mag_b_d     = mag_b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    output_z_d  = output_z_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_a_d = {{WIDTH{1'b0}}, abs_a};
          mag_b_d = abs_b;
          neg_d   = in_signed & (input_a[WIDTH-1] ^ input_b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        // The exit cycle does no iteration. This gives a latency of
        // WIDTH+1 cycles, or highest-set-bit index + 2 on an early exit.
        if ((cnt_q == CNT_LAST) || (EARLY_OUT && (mag_b_q == '0))) begin
          output_z_d  = result;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          if (mag_b_q[0]) begin
            acc_d = acc_q + mag_a_q;
          end
          mag_a_d = mag_a_q << 1;
          mag_b_d = mag_b_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      output_z_q  <= '0;
    end else begin
      state_q     <= state_d;
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      output_z_q  <= output_z_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign output_z  = output_z_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iter_multiplier
//  Description : Scoreboard bench for iter_multiplier. It drives two
//                instances at WIDTH=32: dut0 with EARLY_OUT=0 and dut1 with
//                EARLY_OUT=1. Expected products and latencies are queued when
//                operands are issued. A monitor pops and compares them when
//                each product appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_multiplier;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid0, in_ready0, in_signed0, out_valid0, out_ready0, busy0;
  logic [31:0] input_a0, input_b0;
  logic [63:0] output_z0;
  logic        in_valid1, in_ready1, in_signed1, out_valid1, out_ready1, busy1;
  logic [31:0] input_a1, input_b1;
  logic [63:0] output_z1;

  always #5 clk = ~clk;

  iter_multiplier #(.WIDTH(32), .EARLY_OUT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_signed(in_signed0), .input_a(input_a0), .input_b(input_b0),
    .out_valid(out_valid0), .out_ready(out_ready0), .output_z(output_z0),
    .busy(busy0)
  );

  iter_multiplier #(.WIDTH(32), .EARLY_OUT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_signed(in_signed1), .input_a(input_a1), .input_b(input_b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .output_z(output_z1),
    .busy(busy1)
  );

  typedef struct {
    logic [63:0] z;
    int          lat;   // -1 = latency not checked
    int          acc;   // cycle number of the accepting edge
  } sb_t;

  sb_t q0[$];
  sb_t q1[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  viol = 0;
  int  last_rise0 = 0;
  bit  seen0 = 1'b0;
  bit  seen1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input int sel, input logic [63:0] z);
    sb_t it;
    bit  empty;
    empty = (sel == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      checks++;
      errors++;
      $display("FAIL unexpected_output dut%0d: got 0x%0h expected none", sel, z);
      return;
    end
    if (sel == 0) it = q0.pop_front();
    else          it = q1.pop_front();
    chk($sformatf("product_dut%0d", sel), z, it.z);
    if (it.lat >= 0)
      chk($sformatf("latency_dut%0d", sel), 64'(cyc - it.acc), 64'(it.lat));
  endtask

  // Monitor: compare on the first cycle of each out_valid pulse.
  always @(negedge clk) begin
    if (rst) begin
      seen0 = 1'b0;
      seen1 = 1'b0;
    end else begin
      if (busy0 && in_ready0) viol++;
      if (busy1 && in_ready1) viol++;
      if (out_valid0 && !seen0) begin
        seen0      = 1'b1;
        last_rise0 = cyc;
        sb_check(0, output_z0);
      end
      if (out_valid0 && out_ready0) seen0 = 1'b0;
      if (out_valid1 && !seen1) begin
        seen1 = 1'b1;
        sb_check(1, output_z1);
      end
      if (out_valid1 && out_ready1) seen1 = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic [63:0] z, input int lat,
                       input bit push, input bit hold);
    int n;
    bit rdy;
    n   = 0;
    rdy = (sel == 0) ? in_ready0 : in_ready1;
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
      rdy = (sel == 0) ? in_ready0 : in_ready1;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout dut%0d: in_ready got 0 expected 1", sel);
      return;
    end
    if (sel == 0) begin
      in_valid0 = 1'b1; input_a0 = a; input_b0 = b; in_signed0 = sgn;
    end else begin
      in_valid1 = 1'b1; input_a1 = a; input_b1 = b; in_signed1 = sgn;
    end
    @(negedge clk);
    if (!hold) begin
      if (sel == 0) in_valid0 = 1'b0;
      else          in_valid1 = 1'b0;
    end
    if (push) begin
      if (sel == 0) q0.push_back('{z, lat, cyc});
      else          q1.push_back('{z, lat, cyc});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy0 || busy1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got busy expected idle");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] cap;
    int          n;
    rst = 1'b1;
    in_valid0 = 1'b0; in_signed0 = 1'b0; input_a0 = '0; input_b0 = '0; out_ready0 = 1'b1;
    in_valid1 = 1'b0; in_signed1 = 1'b0; input_a1 = '0; input_b1 = '0; out_ready1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_in_ready",  64'(in_ready0),  64'd1);
    chk("reset_out_valid", 64'(out_valid0), 64'd0);
    chk("reset_output_z",  output_z0,       64'd0);
    chk("reset_busy",      64'(busy0),      64'd0);
    chk("reset_in_ready1", 64'(in_ready1),  64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Directed products, full latency.
    issue(0, 32'd3,          32'd5,          1'b0, 64'd15,                  33, 1'b1, 1'b0); drain();
    issue(0, 32'hFFFFFFF9,   32'd6,          1'b1, 64'hFFFFFFFF_FFFFFFD6,   33, 1'b1, 1'b0); drain();
    issue(0, 32'h80000000,   32'h80000000,   1'b1, 64'h40000000_00000000,   33, 1'b1, 1'b0); drain();
    issue(0, 32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'hFFFFFFFE_00000001,   33, 1'b1, 1'b0); drain();
    issue(0, 32'hFFFFFFFD,   32'd0,          1'b1, 64'd0,                   33, 1'b1, 1'b0); drain();

    // Backpressure: product held, new operands ignored.
    out_ready0 = 1'b0;
    issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1, 33, 1'b1, 1'b0);
    n = 0;
    while (!out_valid0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_rise", 64'(out_valid0), 64'd1);
    cap = output_z0;
    in_valid0 = 1'b1; input_a0 = 32'd9; input_b0 = 32'd9; in_signed0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_output_z_stable", output_z0,       cap);
      chk("bp_out_valid_held",  64'(out_valid0), 64'd1);
      chk("bp_in_ready_low",    64'(in_ready0),  64'd0);
    end
    in_valid0  = 1'b0;
    out_ready0 = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", 64'(out_valid0), 64'd0);
    chk("bp_release_in_ready",  64'(in_ready0),  64'd1);
    chk("bp_release_output_z",  output_z0,       64'd1);
    drain();

    // Reset in the middle of CALC.
    issue(0, 32'd7, 32'd9, 1'b0, 64'd63, -1, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 64'(out_valid0), 64'd0);
    chk("midrst_output_z",  output_z0,       64'd0);
    chk("midrst_in_ready",  64'(in_ready0),  64'd1);
    chk("midrst_busy",      64'(busy0),      64'd0);
    issue(0, 32'd2, 32'd2, 1'b0, 64'd4, 33, 1'b1, 1'b0); drain();

    // Back-to-back with in_valid held high.
    issue(0, 32'd11,       32'd13,       1'b0, 64'd143,                33, 1'b1, 1'b1);
    issue(0, 32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000,  33, 1'b1, 1'b1);
    chk("b2b_accept_gap_2", 64'(cyc - last_rise0), 64'd2);
    issue(0, 32'd5,        32'hFFFFFFFC, 1'b1, 64'hFFFFFFFF_FFFFFFEC,  33, 1'b1, 1'b0);
    chk("b2b_accept_gap_3", 64'(cyc - last_rise0), 64'd2);
    drain();

    // Early termination instance.
    issue(1, 32'd100,      32'd3,        1'b0, 64'd300,               3,  1'b1, 1'b0); drain();
    issue(1, 32'd100,      32'd0,        1'b0, 64'd0,                 1,  1'b1, 1'b0); drain();
    issue(1, 32'd2,        32'h80000000, 1'b0, 64'h00000001_00000000, 33, 1'b1, 1'b0); drain();
    issue(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1,                 2,  1'b1, 1'b0); drain();

    repeat (3) @(negedge clk);
    chk("in_ready_low_while_busy", 64'(viol),      64'd0);
    chk("scoreboard_empty_0",      64'(q0.size()), 64'd0);
    chk("scoreboard_empty_1",      64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
